// File: rtl/csi2_frame_ctrl.sv
// Frame-level capture controller for the CSI-2 pixel-clock stream.
// Gates packets on FS/FE boundaries of one virtual channel and tracks line/frame counts.
module csi2_frame_ctrl #(
    parameter int unsigned VC         = 0,
    parameter int unsigned EXP_LINES  = 0,
    parameter int unsigned LINE_CNT_W = 16
) (
    input  logic                  px_clk_i,
    input  logic                  rst_i,
    input  logic                  capture_en_i,
    input  logic                  single_shot_i,
    input  logic [31:0]           s_tdata_i,
    input  logic [3:0]            s_tstrb_i,
    input  logic                  s_tlast_i,
    input  logic                  s_tvalid_i,
    output logic                  s_tready_o,
    output logic [31:0]           m_tdata_o,
    output logic [3:0]            m_tstrb_o,
    output logic                  m_tlast_o,
    output logic                  m_tvalid_o,
    input  logic                  m_tready_i,
    output logic                  frame_active_o,
    output logic                  armed_o,
    output logic [31:0]           frame_cnt_o,
    output logic [LINE_CNT_W-1:0] line_cnt_o,
    output logic [LINE_CNT_W-1:0] last_lines_o,
    output logic                  frame_err_o
);

    localparam logic [1:0]            VcSel    = 2'(VC);
    localparam logic [LINE_CNT_W-1:0] ExpLines = LINE_CNT_W'(EXP_LINES);
    localparam logic [LINE_CNT_W-1:0] LineOne  = LINE_CNT_W'(1);

    typedef enum logic [1:0] {StDisabled, StArmed, StCapture} state_e;

    state_e                state_q, state_d;
    logic                  sop_q, sop_d;
    logic                  pkt_pass_q, pkt_pass_d;
    logic                  shot_q, shot_d;
    logic                  frame_single_q, frame_single_d;
    logic [31:0]           frame_cnt_q, frame_cnt_d;
    logic [LINE_CNT_W-1:0] line_cnt_q, line_cnt_d;
    logic [LINE_CNT_W-1:0] last_lines_q, last_lines_d;
    logic                  frame_err_q, frame_err_d;

    logic [5:0] hdr_dt;
    logic       vc_match, is_fs, is_fe, is_long;
    logic       pass_hdr, pass, beat, hdr_beat, hdr_ours;

    always_comb begin
        hdr_dt   = s_tdata_i[5:0];
        vc_match = (s_tdata_i[7:6] == VcSel);
        is_fs    = (hdr_dt == 6'h00);
        is_fe    = (hdr_dt == 6'h01);
        is_long  = (hdr_dt >= 6'h10);
        pass_hdr = vc_match &&
                   ((state_q == StCapture) || ((state_q == StArmed) && is_fs));
        // Headers decide live; the rest of the packet follows the latched decision.
        pass       = sop_q ? pass_hdr : pkt_pass_q;
        s_tready_o = pass ? m_tready_i : 1'b1;
        m_tvalid_o = s_tvalid_i && pass;
        beat       = s_tvalid_i && s_tready_o;
        hdr_beat   = beat && sop_q;
        hdr_ours   = hdr_beat && vc_match;
    end

    assign m_tdata_o      = s_tdata_i;
    assign m_tstrb_o      = s_tstrb_i;
    assign m_tlast_o      = s_tlast_i;
    assign frame_active_o = (state_q == StCapture);
    assign armed_o        = (state_q == StArmed);
    assign frame_cnt_o    = frame_cnt_q;
    assign line_cnt_o     = line_cnt_q;
    assign last_lines_o   = last_lines_q;
    assign frame_err_o    = frame_err_q;

    always_comb begin
        state_d        = state_q;
        sop_d          = sop_q;
        pkt_pass_d     = pkt_pass_q;
        shot_d         = shot_q;
        frame_single_d = frame_single_q;
        frame_cnt_d    = frame_cnt_q;
        line_cnt_d     = line_cnt_q;
        last_lines_d   = last_lines_q;
        frame_err_d    = 1'b0;

        if (beat) begin
            sop_d = s_tlast_i;
            if (sop_q) begin
                pkt_pass_d = pass_hdr;
            end
        end
        if (single_shot_i) begin
            shot_d = 1'b1;
        end

        unique case (state_q)
            StDisabled: begin
                if (hdr_ours && is_fe) begin
                    frame_err_d = 1'b1;
                end
                if (capture_en_i || single_shot_i || shot_q) begin
                    state_d = StArmed;
                end
            end
            StArmed: begin
                if (hdr_ours && is_fs) begin
                    state_d        = StCapture;
                    line_cnt_d     = '0;
                    frame_single_d = shot_q || single_shot_i;
                    shot_d         = 1'b0;
                end else begin
                    if (hdr_ours && is_fe) begin
                        frame_err_d = 1'b1;
                    end
                    if (!capture_en_i && !shot_q && !single_shot_i) begin
                        state_d = StDisabled;
                    end
                end
            end
            StCapture: begin
                if (hdr_ours) begin
                    if (is_fe) begin
                        frame_cnt_d    = frame_cnt_q + 32'd1;
                        last_lines_d   = line_cnt_q;
                        frame_single_d = 1'b0;
                        if ((EXP_LINES != 0) && (line_cnt_q != ExpLines)) begin
                            frame_err_d = 1'b1;
                        end
                        // A pending single shot re-arms even with continuous capture off.
                        if ((capture_en_i && !frame_single_q) || shot_q || single_shot_i) begin
                            state_d = StArmed;
                        end else begin
                            state_d = StDisabled;
                        end
                    end else if (is_fs) begin
                        frame_err_d = 1'b1;
                        line_cnt_d  = '0;
                    end else if (is_long && (line_cnt_q != '1)) begin
                        line_cnt_d = line_cnt_q + LineOne;
                    end
                end
            end
            default: state_d = StDisabled;
        endcase
    end

    always_ff @(posedge px_clk_i) begin
        if (rst_i) begin
            state_q        <= StDisabled;
            sop_q          <= 1'b1;
            pkt_pass_q     <= 1'b0;
            shot_q         <= 1'b0;
            frame_single_q <= 1'b0;
            frame_cnt_q    <= '0;
            line_cnt_q     <= '0;
            last_lines_q   <= '0;
            frame_err_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            sop_q          <= sop_d;
            pkt_pass_q     <= pkt_pass_d;
            shot_q         <= shot_d;
            frame_single_q <= frame_single_d;
            frame_cnt_q    <= frame_cnt_d;
            line_cnt_q     <= line_cnt_d;
            last_lines_q   <= last_lines_d;
            frame_err_q    <= frame_err_d;
        end
    end

endmodule

// File: tb/tb_csi2_frame_ctrl.sv
// Directed bench for csi2_frame_ctrl: one instance without and one with a line-count check.
module tb_csi2_frame_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        capture_en, single_shot;
    logic [31:0] s_tdata;
    logic [3:0]  s_tstrb;
    logic        s_tlast, s_tvalid, s_tready;
    logic [31:0] m_tdata;
    logic [3:0]  m_tstrb;
    logic        m_tlast, m_tvalid, m_tready;
    logic        frame_active, armed, frame_err;
    logic [31:0] frame_cnt;
    logic [15:0] line_cnt, last_lines;

    logic        x_s_tready, x_m_tlast, x_m_tvalid, x_active, x_armed, x_err;
    logic [31:0] x_m_tdata, x_frame_cnt;
    logic [3:0]  x_m_tstrb;
    logic [15:0] x_line_cnt, x_last_lines;

    int n_checks = 0;
    int n_errors = 0;
    int vld_cnt  = 0;
    int nrdy_cnt = 0;
    bit tog      = 1'b0;
    logic [32:0] got_q[$];
    logic [32:0] exp_q[$];

    always #5 clk = ~clk;

    csi2_frame_ctrl #(.VC(0), .EXP_LINES(0), .LINE_CNT_W(16)) u_dut (
        .px_clk_i(clk), .rst_i(rst), .capture_en_i(capture_en), .single_shot_i(single_shot),
        .s_tdata_i(s_tdata), .s_tstrb_i(s_tstrb), .s_tlast_i(s_tlast), .s_tvalid_i(s_tvalid),
        .s_tready_o(s_tready), .m_tdata_o(m_tdata), .m_tstrb_o(m_tstrb), .m_tlast_o(m_tlast),
        .m_tvalid_o(m_tvalid), .m_tready_i(m_tready), .frame_active_o(frame_active),
        .armed_o(armed), .frame_cnt_o(frame_cnt), .line_cnt_o(line_cnt),
        .last_lines_o(last_lines), .frame_err_o(frame_err)
    );

    csi2_frame_ctrl #(.VC(0), .EXP_LINES(4), .LINE_CNT_W(16)) u_dut4 (
        .px_clk_i(clk), .rst_i(rst), .capture_en_i(capture_en), .single_shot_i(single_shot),
        .s_tdata_i(s_tdata), .s_tstrb_i(s_tstrb), .s_tlast_i(s_tlast), .s_tvalid_i(s_tvalid),
        .s_tready_o(x_s_tready), .m_tdata_o(x_m_tdata), .m_tstrb_o(x_m_tstrb),
        .m_tlast_o(x_m_tlast), .m_tvalid_o(x_m_tvalid), .m_tready_i(m_tready),
        .frame_active_o(x_active), .armed_o(x_armed), .frame_cnt_o(x_frame_cnt),
        .line_cnt_o(x_line_cnt), .last_lines_o(x_last_lines), .frame_err_o(x_err)
    );

    // Inputs only change 1ns after a rising edge, so the falling edge sees the next beat.
    always @(negedge clk) begin
        if (m_tvalid && m_tready) got_q.push_back({m_tlast, m_tdata});
        if (m_tvalid) vld_cnt++;
        if (!s_tready) nrdy_cnt++;
    end

    always @(posedge clk) begin
        #1;
        m_tready = tog ? ~m_tready : 1'b1;
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] hdr(input logic [5:0] dt, input logic [1:0] vc,
                                        input logic [15:0] wc);
        return {8'h00, wc, vc, dt};
    endfunction

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic put(input logic [31:0] d, input logic last, input bit fwd);
        bit ok;
        int n;
        if (fwd) exp_q.push_back({last, d});
        s_tdata  = d;
        s_tlast  = last;
        s_tvalid = 1'b1;
        n        = 0;
        do begin
            @(negedge clk);
            ok = s_tready;
            @(posedge clk);
            #1;
            n++;
        end while (!ok && n < 64);
        check_eq("beat_accept", 64'(ok), 64'd1);
        s_tvalid = 1'b0;
    endtask

    task automatic send_short(input logic [5:0] dt, input logic [1:0] vc, input bit fwd);
        put(hdr(dt, vc, 16'd0), 1'b1, fwd);
    endtask

    task automatic send_line(input logic [1:0] vc, input logic [7:0] id, input bit fwd);
        put(hdr(6'h2A, vc, 16'd8), 1'b0, fwd);
        put({8'hD0, id, 16'h0001}, 1'b0, fwd);
        put({8'hD0, id, 16'h0002}, 1'b0, fwd);
        put({8'hC0, id, 16'hCCCC}, 1'b1, fwd);
    endtask

    task automatic send_frame(input logic [1:0] vc, input int lines, input logic [7:0] id,
                              input bit fwd);
        send_short(6'h00, vc, fwd);
        for (int i = 0; i < lines; i++) send_line(vc, id + 8'(i), fwd);
        send_short(6'h01, vc, fwd);
    endtask

    task automatic compare_stream(input string tag);
        int diffs = 0;
        check_eq({tag, "_count"}, 64'(got_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            if (got_q[i] !== exp_q[i]) diffs++;
        end
        check_eq({tag, "_data"}, 64'(diffs), 64'd0);
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b0; capture_en = 1'b0; single_shot = 1'b0; m_tready = 1'b1;
        s_tdata = '0; s_tstrb = 4'hF; s_tlast = 1'b0; s_tvalid = 1'b0;
        idle(1);
        do_reset();

        // Reset state, and an FS offered while DISABLED is consumed but not passed.
        check_eq("rst_active", 64'(frame_active), 64'd0);
        check_eq("rst_armed", 64'(armed), 64'd0);
        check_eq("rst_frame_cnt", 64'(frame_cnt), 64'd0);
        check_eq("rst_line_cnt", 64'(line_cnt), 64'd0);
        check_eq("rst_err", 64'(frame_err), 64'd0);
        s_tdata = hdr(6'h00, 2'd0, 16'd0); s_tlast = 1'b1; s_tvalid = 1'b1;
        #1;
        check_eq("rst_m_tvalid", 64'(m_tvalid), 64'd0);
        check_eq("rst_s_tready", 64'(s_tready), 64'd1);
        s_tvalid = 1'b0;
        idle(1);

        // Continuous capture of one three-line frame.
        capture_en = 1'b1;
        idle(2);
        check_eq("t1_armed", 64'(armed), 64'd1);
        send_frame(2'd0, 3, 8'h10, 1'b1);
        check_eq("t1_err_noexp", 64'(frame_err), 64'd0);
        check_eq("t1_err_exp4", 64'(x_err), 64'd1);
        check_eq("t1_frame_cnt", 64'(frame_cnt), 64'd1);
        check_eq("t1_last_lines", 64'(last_lines), 64'd3);
        check_eq("t1_rearmed", 64'(armed), 64'd1);
        idle(1);
        check_eq("t1_err_exp4_pulse", 64'(x_err), 64'd0);
        compare_stream("t1_stream");

        // Capture disabled: everything is dropped at full rate.
        capture_en = 1'b0;
        do_reset();
        vld_cnt = 0; nrdy_cnt = 0;
        send_frame(2'd0, 2, 8'h20, 1'b0);
        check_eq("t2_fe_err", 64'(frame_err), 64'd1);
        idle(1);
        check_eq("t2_m_tvalid_cycles", 64'(vld_cnt), 64'd0);
        check_eq("t2_not_ready_cycles", 64'(nrdy_cnt), 64'd0);
        check_eq("t2_frame_cnt", 64'(frame_cnt), 64'd0);
        check_eq("t2_last_lines", 64'(last_lines), 64'd0);
        compare_stream("t2_stream");

        // Dropping capture_en mid-frame does not truncate the frame.
        do_reset();
        capture_en = 1'b1;
        idle(2);
        send_short(6'h00, 2'd0, 1'b1);
        send_line(2'd0, 8'h30, 1'b1);
        send_line(2'd0, 8'h31, 1'b1);
        check_eq("t3_line_cnt", 64'(line_cnt), 64'd2);
        capture_en = 1'b0;
        send_line(2'd0, 8'h32, 1'b1);
        check_eq("t3_still_active", 64'(frame_active), 64'd1);
        send_short(6'h01, 2'd0, 1'b1);
        check_eq("t3_active_after_fe", 64'(frame_active), 64'd0);
        check_eq("t3_armed_after_fe", 64'(armed), 64'd0);
        check_eq("t3_frame_cnt", 64'(frame_cnt), 64'd1);
        send_frame(2'd0, 1, 8'h33, 1'b0);
        compare_stream("t3_stream");

        // Single shot: only the first of two frames is captured.
        do_reset();
        single_shot = 1'b1;
        idle(1);
        single_shot = 1'b0;
        idle(1);
        check_eq("t4_armed", 64'(armed), 64'd1);
        send_frame(2'd0, 2, 8'h40, 1'b1);
        send_frame(2'd0, 2, 8'h50, 1'b0);
        check_eq("t4_frame_cnt", 64'(frame_cnt), 64'd1);
        check_eq("t4_armed_after", 64'(armed), 64'd0);
        compare_stream("t4_stream");

        // Stray FE, repeated FS, then a correct four-line frame.
        do_reset();
        capture_en = 1'b1;
        idle(2);
        send_short(6'h01, 2'd0, 1'b0);
        check_eq("t5_stray_fe_err", 64'(frame_err), 64'd1);
        idle(1);
        check_eq("t5_stray_fe_pulse", 64'(frame_err), 64'd0);
        send_short(6'h00, 2'd0, 1'b1);
        send_line(2'd0, 8'h60, 1'b1);
        send_line(2'd0, 8'h61, 1'b1);
        check_eq("t5_line_cnt_pre", 64'(line_cnt), 64'd2);
        send_short(6'h00, 2'd0, 1'b1);
        check_eq("t5_refs_err", 64'(frame_err), 64'd1);
        check_eq("t5_refs_line_cnt", 64'(line_cnt), 64'd0);
        check_eq("t5_refs_active", 64'(frame_active), 64'd1);
        for (int i = 0; i < 4; i++) send_line(2'd0, 8'h70 + 8'(i), 1'b1);
        send_short(6'h01, 2'd0, 1'b1);
        check_eq("t5_exp4_ok", 64'(x_err), 64'd0);
        check_eq("t5_last_lines", 64'(x_last_lines), 64'd4);
        check_eq("t5_frame_cnt", 64'(frame_cnt), 64'd1);
        compare_stream("t5_stream");

        // Interleaved VC1 traffic with a toggling output ready.
        do_reset();
        capture_en = 1'b1;
        tog = 1'b1;
        idle(2);
        send_short(6'h00, 2'd0, 1'b1);
        send_short(6'h00, 2'd1, 1'b0);
        send_line(2'd0, 8'h80, 1'b1);
        send_line(2'd1, 8'h90, 1'b0);
        send_short(6'h01, 2'd1, 1'b0);
        check_eq("t6_vc1_fe_no_err", 64'(frame_err), 64'd0);
        send_line(2'd0, 8'h81, 1'b1);
        send_short(6'h01, 2'd0, 1'b1);
        check_eq("t6_frame_cnt", 64'(frame_cnt), 64'd1);
        check_eq("t6_last_lines", 64'(last_lines), 64'd2);
        tog = 1'b0;
        idle(2);
        compare_stream("t6_stream");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
